// File: rtl/data_mem_responder_pkg.sv
// Shared FSM encoding, default sizing and the access-fault rule for the data memory responder.
// No logic of its own; latency and backpressure live in the modules that import it.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_WAIT_CYCLES = 2;

  // Misaligned, or beyond the last word of a memory with 2**aw words.
  function automatic logic addr_fault(input logic [31:0] addr, input int aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port word RAM: synchronous write, registered read (read-before-write on the same index).
// One-cycle read latency; no backpressure, contents are never reset.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the execute stage: accepts one load/store, answers after WAIT_CYCLES+1 cycles.
// memStall holds the pipeline from the request cycle until DONE; requests are ignored outside IDLE.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memoryRead,
  input  logic        memoryWrite,
  input  logic [31:0] memoryAddressOut,
  input  logic [31:0] memoryDataOut,
  output logic [31:0] memoryDataIn,
  output logic        memStall,
  output logic        memReady,
  output logic        memError
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rd_q;
  logic        wr_q;
  logic        rdy_q;
  logic        err_q;
  logic        rvld_q;

  logic        req;
  logic        idle;
  logic        cur_rd;
  logic        cur_wr;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        fault;
  logic        done_entry;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  assign req  = memoryRead | memoryWrite;
  assign idle = (state_q == IDLE);

  // With zero wait states DONE is entered on the acceptance edge, so the live inputs feed the RAM.
  assign cur_rd    = idle ? memoryRead       : rd_q;
  assign cur_wr    = idle ? memoryWrite      : wr_q;
  assign cur_addr  = idle ? memoryAddressOut : addr_q;
  assign cur_wdata = idle ? memoryDataOut    : wdata_q;
  assign fault     = addr_fault(cur_addr, AW);

  assign done_entry = !rst && ((idle && req && (WAIT_CYCLES == 0)) ||
                               ((state_q == WAIT) && (cnt_q == 4'd0)));
  assign ram_we     = done_entry && cur_wr && !fault;
  assign ram_re     = done_entry && cur_rd && !cur_wr && !fault;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_dmem_array (
    .clk    (clk),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .idx_i  (cur_addr[AW+1:2]),
    .wdata_i(cur_wdata),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      rdy_q  <= done_entry;
      err_q  <= done_entry && (fault || (cur_rd && cur_wr));
      rvld_q <= ram_re;
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= memoryAddressOut;
            wdata_q <= memoryDataOut;
            rd_q    <= memoryRead;
            wr_q    <= memoryWrite;
            if (WAIT_CYCLES > 0) begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
            end else begin
              state_q <= DONE;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memStall     = (idle && req) || (state_q == WAIT);
  assign memReady     = rdy_q;
  assign memError     = err_q;
  assign memoryDataIn = rvld_q ? ram_rdata : 32'd0;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter DEPTH_WORDS, 256, number of 32-bit data words; a power of two, 16..4096.
REQ-003 Parameter WAIT_CYCLES, 2, wait states between request acceptance and response; 0..15.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 memoryRead  input  1  load request from execute.
REQ-007 memoryWrite  input  1  store request from execute.
REQ-008 memoryAddressOut  input  32  byte address from execute.
REQ-009 memoryDataOut  input  32  store data from execute.
REQ-010 memoryDataIn  output  32  load data returned to execute.
REQ-011 memStall  output  1  high while a request is in flight; the pipeline holds.
REQ-012 memReady  output  1  one-cycle pulse marking completion.
REQ-013 memError  output  1  one-cycle pulse, coincident with memReady, marking a faulted access.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-015 IDLE: if (memoryRead | memoryWrite) is sampled high, the block SHALL latch the address, store data, and operation type.
REQ-016 IDLE transitions: to WAIT if WAIT_CYCLES>0, else directly to DONE.
REQ-017 WAIT: a 4-bit counter SHALL load WAIT_CYCLES-1 on entry and decrement each cycle; the FSM goes to DONE when the counter is 0.
REQ-018 DONE lasts exactly one cycle and SHALL return to IDLE.
REQ-019 Request inputs SHALL be ignored in WAIT and DONE; a request still asserted in DONE is accepted on the following IDLE cycle.
REQ-020 Total latency from acceptance edge to memReady SHALL be WAIT_CYCLES+1 cycles.
REQ-021 memStall SHALL be 1 combinationally in IDLE when a request is present, and 1 in WAIT; it SHALL be 0 in DONE and in idle IDLE.
REQ-022 Word index = latched address[log2(DEPTH_WORDS)+1:2].
REQ-023 Fault conditions: address[1:0]!=0 (misaligned), or address >= 4*DEPTH_WORDS (out of range).
REQ-024 On a fault: no write; memoryDataIn=0; memError=1 in DONE.
REQ-025 Write: memory SHALL be updated on the DONE-entry edge; memoryDataIn=0 in DONE.
REQ-026 Read: the word SHALL be registered on the DONE-entry edge and driven on memoryDataIn during DONE only; memoryDataIn=0 in all other states.
REQ-027 If memoryRead and memoryWrite are both high, write wins and memError SHALL pulse; the write still commits if the address is valid.
REQ-028 Read data SHALL reflect all writes completed earlier, including a write to the same address in the immediately preceding transaction.

Reset
REQ-029 rst SHALL force IDLE, the counter to 0, and memStall/memReady/memError/memoryDataIn to 0 on the next edge.
REQ-030 rst asserted in WAIT SHALL abort the transaction: no write, no memReady.
REQ-031 Memory array contents SHALL NOT be reset.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2) and the default constants DEPTH_WORDS and WAIT_CYCLES.
REQ-033 The storage SHALL be one sub-module, dmem_array: a single-port synchronous RAM with write enable, word index, wdata, and registered rdata.

Verification
REQ-034 Reset, then write 0xDEADBEEF to 0x10, then read 0x10 (WAIT_CYCLES=2) -> memReady 3 cycles after each acceptance; read returns 0xDEADBEEF; memError=0.
REQ-035 Read 0x12 (misaligned) -> memReady and memError together; memoryDataIn=0; memory unchanged.
REQ-036 Write 0x12345678 to 0x400 with DEPTH_WORDS=256 -> memError=1; a read of 0x0 returns its prior value.
REQ-037 memoryRead and memoryWrite high together, addr 0x20, data 0xA5A5A5A5 -> memError=1; a later read of 0x20 returns 0xA5A5A5A5.
REQ-038 Write to 0x30 accepted, rst pulsed in WAIT -> no memReady; block in IDLE; a read of 0x30 returns its old value.
REQ-039 WAIT_CYCLES=0, back-to-back reads held high for 4 cycles -> memReady every second cycle; memStall high only on acceptance cycles.
